reverb_param_loader: RTL
========================

# reverb_param_loader

Parameter writer for the reverberator: accepts addressed tau/gain writes from the control path through a valid/ready handshake, holds them in shadow registers, and on commit transfers the whole set atomically to the active `tau`/`gain` arrays at the next sample boundary. It sits between the control path (MCU/SPI register decoder) and `reverberator_core`. It guarantees that the filters never see a half-updated parameter set, a delay outside the FIFO range, or a gain at or above 1.0.

## Interface
- `WIDTH`, 24, integer part width; `WORD = WIDTH + `FIXED_POINT`.
- `MAXDELAY`, `MAX_FILTER_FIFO_LENGTH`, upper bound for any tau.
- `RAMP_STEP`, 1, gain slew step in LSBs per sample tick (used only with ramp enabled).
- `clk`  in  1  system clock; single clock domain for the whole block.
- `rstn`  in  1  asynchronous, active-low reset.
- `sample_tick`  in  1  one-`clk` pulse marking a sample boundary.
- `wr_valid`  in  1  write request.
- `wr_ready`  out  1  write accepted when `wr_valid && wr_ready`.
- `wr_addr`  in  4  0–5 select tau[0..5]; 6–12 select gain[0..6]; 13–15 invalid.
- `wr_data`  in  WORD  signed value; tau is a sample count, gain is fixed point.
- `commit`  in  1  pulse requesting transfer of shadow to active.
- `tau`  out  [0:5][WORD]  active delays, signed packed.
- `gain`  out  [0:6][WORD]  active gains, signed packed.
- `busy`  out  1  commit pending, or a gain still slewing.
- `commit_done`  out  1  one-cycle pulse on the apply cycle.
- `err`  out  2  sticky flags: [0] invalid address, [1] value clamped; cleared only by reset.

## Operation
- Clamping is applied when a write lands in shadow:
  - tau is clamped to [1, MAXDELAY-1].
  - gain is clamped to [-(ONE-1), ONE-1], where ONE = 1 << `FIXED_POINT`.
  - Any clamp sets err[1].
- A write to an invalid address is accepted (handshake completes), its data is dropped, and err[0] is set.
- FSM states:
  - IDLE: `wr_ready`=1. `commit` moves the FSM to PENDING.
  - PENDING: `wr_ready`=0. `sample_tick` moves the FSM to APPLY.
  - APPLY: one cycle. Shadow is copied to active target, `commit_done`=1, then return to IDLE.
- A write handshake and `commit` in the same IDLE cycle: the write lands first and is included in the commit.
- `commit` while in PENDING or APPLY is ignored.
- Shadow contents persist after commit; a later commit without new writes re-applies the same values.
- Reset values:
  - shadow and active tau = 1; shadow and active gain = 0 (gain[6]=0 gives dry passthrough).
  - `wr_ready`=1, `busy`=0, `commit_done`=0, `err`=0, state IDLE.
- Reset asserted mid-operation aborts any pending commit; all outputs return to their reset values immediately (asynchronously).

## Timing
- Write to shadow: 1 cycle after the handshake.
- Commit latency: `commit` at cycle c → PENDING at c+1. The first `sample_tick` at cycle t ≥ c+1 → APPLY at t+1. Active outputs are updated at t+2.
- A `sample_tick` in the same cycle as `commit` does not apply; the commit waits for the next tick.
- `busy` is high from c+1 until the cycle after APPLY, or until the slew completes if later.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `REVERB_PARAM_RAMP_EN` defined:
  - On APPLY, gain targets update, but each `gain[i]` output moves toward its target by at most `RAMP_STEP` per `sample_tick`, landing exactly on the target.
  - tau still switches at APPLY.
  - A new commit mid-slew retargets from the current output value.
  - `busy` stays high until all gains equal their targets.
- Macro undefined: gains switch at APPLY together with tau; `RAMP_STEP` is unused.

## Structure
- Shared package `reverb_pkg` holds:
  - constants NCOMB=4, NALLP=2, NTAU=6, NGAIN=7;
  - address map localparams (TAU_BASE=0, GAIN_BASE=6, ADDR_LAST=12);
  - the FSM state enum `param_state_t`;
  - the `word_t` typedef.
- Sub-module `gain_slew`: one instance per gain, generated only under `REVERB_PARAM_RAMP_EN`. Register plus saturating step-toward-target on tick.

## Test plan
All values below assume the `FIXED_POINT=8` build.
- Reset, then no activity → tau all 1, gain all 0, `wr_ready`=1, `err`=0.
- Write tau[0]=1116, gain[0]=0xB3 (0.699), then `commit`, then `sample_tick` 5 cycles later → outputs unchanged until tick+2, then tau[0]=1116 and gain[0]=0xB3; one `commit_done` pulse.
- Write gain[2]=0x180 (1.5) and tau[1]=MAXDELAY+10 → shadow holds 0xFF and MAXDELAY-1; err=2'b10.
- Write to addr 14 → handshake completes, no register changes, err[0]=1.
- `commit`, then `wr_valid` held with no tick for 20 cycles → `wr_ready`=0 throughout; the write completes after APPLY.
- With ramp enabled and RAMP_STEP=16, commit gain[6] 0→0x40 → values 16, 32, 48, 64 on successive ticks; `busy` drops after 64. Repeat with `rstn` pulsed mid-ramp → all gains 0 immediately.

Source files
------------

// File: rtl/reverb_pkg.sv
// reverb_pkg: constants, address map, FSM state type and word type shared
// by the reverberator parameter path.
//
// Build-time macros:
//   FIXED_POINT            - fractional bits of a parameter word (default 8)
//   MAX_FILTER_FIFO_LENGTH - longest delay FIFO in the core (default 4096)
//   REVERB_PARAM_RAMP_EN   - enables gain slewing in reverb_param_loader

`ifndef FIXED_POINT
`define FIXED_POINT 8
`endif

`ifndef MAX_FILTER_FIFO_LENGTH
`define MAX_FILTER_FIFO_LENGTH 4096
`endif

package reverb_pkg;

    localparam int NCOMB = 4;
    localparam int NALLP = 2;
    localparam int NTAU  = 6;
    localparam int NGAIN = 7;

    localparam int FRAC_W = `FIXED_POINT;
    localparam int INT_W  = 24;
    localparam int WORD_W = INT_W + FRAC_W;

    // Control-path address map: taus first, then gains; the rest is invalid.
    localparam logic [3:0] TAU_BASE  = 4'd0;
    localparam logic [3:0] GAIN_BASE = 4'd6;
    localparam logic [3:0] ADDR_LAST = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_APPLY   = 2'd2
    } param_state_t;

    typedef logic signed [WORD_W-1:0] word_t;

endpackage

// File: rtl/reverb_param_loader_gain_slew.sv
// gain_slew: one slewed gain output. Holds a target and a current value;
// on every sample tick the value moves toward the target by at most STEP
// LSBs and lands exactly on it. Only present in REVERB_PARAM_RAMP_EN builds.
//
// Ports:
//   clk, rstn     - clock, asynchronous active-low reset
//   sample_tick   - sample boundary pulse; one step per tick
//   load          - capture target_in as the new target
//   target_in     - new target (signed fixed point)
//   value         - current slewed gain
//   settled       - value equals target

`ifdef REVERB_PARAM_RAMP_EN
module gain_slew #(
    parameter int WORD = 32,
    parameter int STEP = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            sample_tick,
    input  logic            load,
    input  logic [WORD-1:0] target_in,
    output logic [WORD-1:0] value,
    output logic            settled
);

    localparam logic signed [WORD:0]   STEP_W = (WORD+1)'(STEP);
    localparam logic signed [WORD-1:0] STEP_V = WORD'(STEP);

    logic signed [WORD-1:0] target_q;
    logic signed [WORD-1:0] value_q;
    logic signed [WORD:0]   diff;
    logic signed [WORD-1:0] value_nx;

    // One extra bit so the distance between two full-range words cannot wrap.
    assign diff = {target_q[WORD-1], target_q} - {value_q[WORD-1], value_q};

    always_comb begin
        value_nx = target_q;
        if (diff > STEP_W)
            value_nx = value_q + STEP_V;
        else if (diff < -STEP_W)
            value_nx = value_q - STEP_V;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            target_q <= '0;
            value_q  <= '0;
        end else begin
            if (load)
                target_q <= $signed(target_in);
            if (sample_tick)
                value_q <= value_nx;
        end
    end

    assign value   = value_q;
    assign settled = (value_q == target_q);

endmodule
`endif

// File: rtl/reverb_param_loader.sv
// reverb_param_loader: collects addressed tau/gain writes into shadow
// registers (clamped on entry) and, on commit, transfers the whole set to
// the active outputs at the next sample boundary so the filters never see a
// half-updated set.
//
// Ports:
//   clk, rstn    - clock, asynchronous active-low reset
//   sample_tick  - one-cycle sample boundary pulse
//   wr_valid/wr_ready, wr_addr, wr_data - write channel (0-5 tau, 6-12 gain)
//   commit       - request shadow -> active transfer
//   tau, gain    - active parameter sets
//   busy         - commit pending or gain still slewing
//   commit_done  - pulse on the apply cycle
//   err          - sticky [0] invalid address, [1] value clamped
//
// Optional feature: define REVERB_PARAM_RAMP_EN to slew gains by RAMP_STEP
// per sample tick instead of switching them at apply.

module reverb_param_loader
    import reverb_pkg::*;
#(
    parameter int WIDTH     = 24,
    parameter int MAXDELAY  = `MAX_FILTER_FIFO_LENGTH,
    parameter int RAMP_STEP = 1
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             sample_tick,
    input  logic                             wr_valid,
    output logic                             wr_ready,
    input  logic [3:0]                       wr_addr,
    input  logic [WIDTH+`FIXED_POINT-1:0]    wr_data,
    input  logic                             commit,
    output logic [0:NTAU-1][WIDTH+`FIXED_POINT-1:0]  tau,
    output logic [0:NGAIN-1][WIDTH+`FIXED_POINT-1:0] gain,
    output logic                             busy,
    output logic                             commit_done,
    output logic [1:0]                       err
);

    localparam int WORD = WIDTH + `FIXED_POINT;

    localparam logic signed [WORD-1:0] TAU_MIN  = WORD'(1);
    localparam logic signed [WORD-1:0] TAU_MAX  = WORD'(MAXDELAY - 1);
    localparam logic signed [WORD-1:0] GAIN_MAX = WORD'((1 << `FIXED_POINT) - 1);
    localparam logic signed [WORD-1:0] GAIN_MIN = -GAIN_MAX;

    if (RAMP_STEP < 1 || MAXDELAY < 2) begin : g_param_check
        $error("reverb_param_loader: RAMP_STEP must be >= 1 and MAXDELAY >= 2");
    end

    function automatic logic signed [WORD-1:0] sat(
        input logic signed [WORD-1:0] v,
        input logic signed [WORD-1:0] lo,
        input logic signed [WORD-1:0] hi
    );
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    param_state_t state;

    logic signed [WORD-1:0] sh_tau  [NTAU];
    logic signed [WORD-1:0] sh_gain [NGAIN];

    logic                   wr_fire;
    logic                   is_tau;
    logic                   is_gain;
    logic [2:0]             tau_idx;
    logic [2:0]             gain_idx;
    logic signed [WORD-1:0] din;
    logic signed [WORD-1:0] tau_val;
    logic signed [WORD-1:0] gain_val;
    logic                   apply;
    logic                   slewing;

    assign wr_fire  = wr_valid && wr_ready;
    assign is_tau   = (wr_addr < GAIN_BASE);
    assign is_gain  = (wr_addr >= GAIN_BASE) && (wr_addr <= ADDR_LAST);
    assign tau_idx  = 3'(wr_addr - TAU_BASE);
    assign gain_idx = 3'(wr_addr - GAIN_BASE);
    assign din      = $signed(wr_data);
    assign tau_val  = sat(din, TAU_MIN, TAU_MAX);
    assign gain_val = sat(din, GAIN_MIN, GAIN_MAX);
    assign apply    = (state == ST_APPLY);

    // Shadow registers and sticky error flags. Writes are only accepted in
    // IDLE, so the shadow set is frozen while a commit is in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NTAU; i++)  sh_tau[i]  <= TAU_MIN;
            for (int i = 0; i < NGAIN; i++) sh_gain[i] <= '0;
            err <= 2'b00;
        end else if (wr_fire) begin
            if (is_tau) begin
                sh_tau[tau_idx] <= tau_val;
                if (tau_val != din) err[1] <= 1'b1;
            end else if (is_gain) begin
                sh_gain[gain_idx] <= gain_val;
                if (gain_val != din) err[1] <= 1'b1;
            end else begin
                err[0] <= 1'b1;
            end
        end
    end

    // Commit sequencer: IDLE -> PENDING on commit, PENDING -> APPLY on the
    // next tick seen while pending, APPLY lasts one cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            wr_ready    <= 1'b1;
            commit_done <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (commit) begin
                        state    <= ST_PENDING;
                        wr_ready <= 1'b0;
                    end
                end
                ST_PENDING: begin
                    if (sample_tick) begin
                        state       <= ST_APPLY;
                        commit_done <= 1'b1;
                    end
                end
                ST_APPLY: begin
                    state       <= ST_IDLE;
                    wr_ready    <= 1'b1;
                    commit_done <= 1'b0;
                end
                default: begin
                    state       <= ST_IDLE;
                    wr_ready    <= 1'b1;
                    commit_done <= 1'b0;
                end
            endcase
        end
    end

    // Active delays always switch on the apply cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NTAU; i++) tau[i] <= WORD'(1);
        end else if (apply) begin
            for (int i = 0; i < NTAU; i++) tau[i] <= sh_tau[i];
        end
    end

`ifdef REVERB_PARAM_RAMP_EN
    logic [NGAIN-1:0] settled;

    for (genvar g = 0; g < NGAIN; g++) begin : g_slew
        gain_slew #(
            .WORD (WORD),
            .STEP (RAMP_STEP)
        ) u_slew (
            .clk         (clk),
            .rstn        (rstn),
            .sample_tick (sample_tick),
            .load        (apply),
            .target_in   (sh_gain[g]),
            .value       (gain[g]),
            .settled     (settled[g])
        );
    end

    assign slewing = ~&settled;
`else
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NGAIN; i++) gain[i] <= '0;
        end else if (apply) begin
            for (int i = 0; i < NGAIN; i++) gain[i] <= sh_gain[i];
        end
    end

    assign slewing = 1'b0;
`endif

    // Decoded from registers only, so no input reaches busy combinationally.
    assign busy = (state != ST_IDLE) || slewing;

endmodule
